twiddle_mult_stage: RTL and testbench
=====================================

TWIDDLE_MULT_STAGE -- requirements
Module: twiddle_mult_stage

Interface
REQ-001 Parameter N_POINTS, default 16, DFT length; power of two, 4..256.
REQ-002 Parameter LOG2N, default $clog2(N_POINTS), counter/index width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin frame; sampled in IDLE only.
REQ-006 k_bin  input  LOG2N  DFT bin index; latched on accepted start.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_data  input  32  sample {re[31:16], im[15:0]}, signed Q1.15.
REQ-009 in_ready  output  1  stage accepts sample this cycle.
REQ-010 out_valid  output  1  product valid; drives downstream accumulator ce.
REQ-011 out_data  output  32  product {re[31:16], im[15:0]}, signed Q1.15.
REQ-012 frame_done  output  1  one-cycle pulse after the frame's last product leaves.
REQ-013 busy  output  1  high in RUN or FLUSH.

Function
REQ-014 FSM SHALL have states IDLE, RUN, FLUSH.
REQ-015 IDLE: in_ready=0; start=1 SHALL latch k_bin, clear sample count n and phase index p to 0, go to RUN.
REQ-016 RUN: in_ready=1; accept = in_valid & in_ready; each accept SHALL tag the sample with p, then p <= (p + k) mod N_POINTS, n <= n + 1.
REQ-017 Accept of sample N_POINTS-1 SHALL move RUN->FLUSH; in FLUSH in_ready=0.
REQ-018 FLUSH SHALL wait until no valid sample remains in the pipeline, pulse frame_done for one cycle, return to IDLE.
REQ-019 in_valid=0 in RUN SHALL stall n and p; the pipeline advances with bubbles (out_valid=0 for them).
REQ-020 Latency SHALL be fixed at 3 cycles: accept at edge t -> out_valid=1 with result after edge t+3; throughput one sample per cycle.
REQ-021 No output backpressure; every accepted sample SHALL produce exactly one out_valid cycle; N_POINTS per frame.
REQ-022 Twiddle W[p] = c - j*s, c = cos(2*pi*p/N), s = sin(2*pi*p/N), Q1.15, +1.0 stored as 32767.
REQ-023 Product (a+jb)*W: re = a*c + b*s, im = b*c - a*s; 32-bit partial products, 33-bit sums, arithmetic shift right 15.
REQ-024 Result outside [-32768, 32767] SHALL saturate to the bound, per component.
REQ-025 start in RUN/FLUSH SHALL be ignored; k_bin changes after latch SHALL have no effect.
REQ-026 Reset and start in the same cycle: reset wins.

Reset
REQ-027 nrst=0 SHALL force IDLE, n=p=0, latched k=0, all pipeline valid bits 0.
REQ-028 Reset values: in_ready=0, out_valid=0, out_data=0, frame_done=0, busy=0.
REQ-029 Reset mid-frame SHALL discard in-flight samples with no out_valid and no frame_done.

Configuration
REQ-030 Macro TWIDDLE_ROUND_EN defined: add 2^14 before the shift (round half up).
REQ-031 TWIDDLE_ROUND_EN undefined: plain arithmetic shift (truncate toward -inf); latency unchanged either way.

Structure
REQ-032 Package fft_pkg SHALL hold the complex sample typedef (re/im signed 16), the Q1.15 constants (Q_ONE=32767, Q_FRAC=15) and the saturation function.
REQ-033 Sub-module twiddle_rom (param N_POINTS, input p, registered output {c,s}, one-cycle read) SHALL form pipeline stage 1.

Verification
REQ-034 N=16, k=0, in 0x4000_0000 -> out 0x3FFF_0000 (truncate) / 0x4000_0000 (TWIDDLE_ROUND_EN), 3 cycles after accept.
REQ-035 N=16, k=4, sample 1 = 0x4000_0000 (p=4, W=-j) -> out 0x0000_C000 (truncate) / 0x0000_C001 (round).
REQ-036 N=16, k=2, sample 1 = 0x8000_8000 (p=2, c=s=23170) -> re -46340 saturates, out 0x8000_0000.
REQ-037 16 samples with in_valid toggling 1,0 -> exactly 16 out_valid pulses, frame_done 1 cycle after last, busy falls with it.
REQ-038 nrst=0 after 7 accepted samples -> out_valid stays 0, no frame_done, next start restarts with p=0.
REQ-039 start pulsed during RUN with new k_bin -> ignored; p sequence follows the original k.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg : shared Q1.15 complex types, constants and saturation helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package fft_pkg;
  localparam int Q_ONE  = 32767;
  localparam int Q_FRAC = 15;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767)  return 16'sh7FFF;
    if (x < -33'sd32768) return 16'sh8000;
    return 16'(x);
  endfunction
endpackage
`default_nettype wire

// File: rtl/twiddle_mult_stage_if.sv
// ---------------------------------------------------------------------------
// twiddle_mult_stage_if : frame control, sample in/out bus of the stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
interface twiddle_mult_stage_if #(
  parameter int N_POINTS = 16,
  parameter int LOG2N    = $clog2(N_POINTS)
);
  logic             i_start;
  logic [LOG2N-1:0] i_k_bin;
  logic             i_in_valid;
  logic [31:0]      i_in_data;
  logic             o_in_ready;
  logic             o_out_valid;
  logic [31:0]      o_out_data;
  logic             o_frame_done;
  logic             o_busy;

  modport slave (
    input  i_start, i_k_bin, i_in_valid, i_in_data,
    output o_in_ready, o_out_valid, o_out_data, o_frame_done, o_busy
  );

  modport master (
    output i_start, i_k_bin, i_in_valid, i_in_data,
    input  o_in_ready, o_out_valid, o_out_data, o_frame_done, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/twiddle_rom.sv
// ---------------------------------------------------------------------------
// twiddle_rom : registered {cos, sin} lookup in Q1.15, one-cycle read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int LOG2N    = $clog2(N_POINTS)
) (
  input  wire logic                    clk,
  input  wire logic                    nrst,
  input  wire logic [LOG2N-1:0]        i_p,
  output logic signed [15:0]           o_c,
  output logic signed [15:0]           o_s
);
  localparam real c_PI = 3.14159265358979323846;

  // +1.0 cannot be represented, so it is clamped to Q_ONE
  function automatic logic signed [15:0] q15(input real x);
    int v;
    v = int'(x * 32768.0);
    if (v > Q_ONE) v = Q_ONE;
    return 16'(v);
  endfunction

  logic signed [15:0] w_cos [N_POINTS];
  logic signed [15:0] w_sin [N_POINTS];

  for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_rom
    assign w_cos[gi] = q15($cos(2.0 * c_PI * real'(gi) / real'(N_POINTS)));
    assign w_sin[gi] = q15($sin(2.0 * c_PI * real'(gi) / real'(N_POINTS)));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      o_c <= '0;
      o_s <= '0;
    end else begin
      o_c <= w_cos[i_p];
      o_s <= w_sin[i_p];
    end
  end
endmodule
`default_nettype wire

// File: rtl/twiddle_mult_stage.sv
// ---------------------------------------------------------------------------
// twiddle_mult_stage : multiplies each frame sample by W^(n*k), 3-cycle pipe
// Rev 1.0  Option macro: TWIDDLE_ROUND_EN (round half up before the shift)
// ---------------------------------------------------------------------------
`default_nettype none
module twiddle_mult_stage
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int LOG2N    = $clog2(N_POINTS)
) (
  input wire logic              clk,
  input wire logic              nrst,
  twiddle_mult_stage_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

`ifdef TWIDDLE_ROUND_EN
  localparam logic signed [32:0] c_RND = 33'sd16384;
`else
  localparam logic signed [32:0] c_RND = '0;
`endif

  logic [1:0]          r_state;
  logic [LOG2N-1:0]    r_k, r_p, r_n;
  logic                r_done;
  logic                r_v1, r_v2, r_v3, r_ov;
  cplx_t               r_x1;
  logic signed [15:0]  w_c, w_s;
  logic signed [31:0]  r_ac, r_bs, r_bc, r_as;
  logic signed [32:0]  r_re_sum, r_im_sum;
  logic [31:0]         r_od;
  logic                w_accept, w_last;
  logic signed [32:0]  w_re_sum, w_im_sum, w_re_sh, w_im_sh;

  assign w_accept = (r_state == S_RUN) && bus.i_in_valid;
  assign w_last   = w_accept && (r_n == LOG2N'(N_POINTS - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_p     <= '0;
      r_n     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_k     <= bus.i_k_bin;
          r_p     <= '0;
          r_n     <= '0;
          r_state <= S_RUN;
        end
        // N_POINTS is a power of two, so the phase wraps modulo N for free
        S_RUN: if (w_accept) begin
          r_p <= r_p + r_k;
          r_n <= r_n + 1'b1;
          if (w_last) r_state <= S_FLUSH;
        end
        S_FLUSH: if (!(r_v1 || r_v2 || r_v3)) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  twiddle_rom #(.N_POINTS(N_POINTS), .LOG2N(LOG2N)) u_rom (
    .clk  (clk),
    .nrst (nrst),
    .i_p  (r_p),
    .o_c  (w_c),
    .o_s  (w_s)
  );

  assign w_re_sum = 33'(r_ac) + 33'(r_bs);
  assign w_im_sum = 33'(r_bc) - 33'(r_as);
  assign w_re_sh  = (r_re_sum + c_RND) >>> Q_FRAC;
  assign w_im_sh  = (r_im_sum + c_RND) >>> Q_FRAC;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_ov     <= 1'b0;
      r_x1     <= '0;
      r_ac     <= '0;
      r_bs     <= '0;
      r_bc     <= '0;
      r_as     <= '0;
      r_re_sum <= '0;
      r_im_sum <= '0;
      r_od     <= '0;
    end else begin
      r_v1     <= w_accept;
      r_x1     <= bus.i_in_data;
      r_v2     <= r_v1;
      r_ac     <= 32'(r_x1.re) * 32'(w_c);
      r_bs     <= 32'(r_x1.im) * 32'(w_s);
      r_bc     <= 32'(r_x1.im) * 32'(w_c);
      r_as     <= 32'(r_x1.re) * 32'(w_s);
      r_v3     <= r_v2;
      r_re_sum <= w_re_sum;
      r_im_sum <= w_im_sum;
      r_ov     <= r_v3;
      r_od     <= {sat16(w_re_sh), sat16(w_im_sh)};
    end
  end

  assign bus.o_in_ready   = (r_state == S_RUN);
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_out_valid  = r_ov;
  assign bus.o_out_data   = r_od;
  assign bus.o_frame_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_twiddle_mult_stage.sv
// ---------------------------------------------------------------------------
// tb_twiddle_mult_stage : directed vectors, queue scoreboard with output monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_twiddle_mult_stage;
  import fft_pkg::*;
  localparam int N = 16;
`ifdef TWIDDLE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  twiddle_mult_stage_if #(.N_POINTS(N)) bus();
  twiddle_mult_stage #(.N_POINTS(N)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, ov_count = 0, fd_count = 0;
  int          fd_cyc = -1, last_ov_cyc = -1;
  logic        prev_fd = 1'b0;
  logic [31:0] vd[N], ve[N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.o_out_valid) begin
      ov_count++;
      last_ov_cyc = cyc;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: out_data=%h, none pending", bus.o_out_data);
      end else begin
        e = sb.pop_front();
        if (bus.o_out_data !== e.data) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", bus.o_out_data, e.data);
        end
        n_tests++;
        if (cyc - e.cyc != 3) begin
          n_fail++;
          $display("FAIL latency: got %0d expected 3", cyc - e.cyc);
        end
      end
    end
    if (bus.o_frame_done) begin
      fd_count++;
      fd_cyc = cyc;
      n_tests++;
      if (bus.o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_at_done: got %b expected 0", bus.o_busy);
      end
      n_tests++;
      if (prev_fd !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse_width: frame_done high two cycles");
      end
    end
    prev_fd = bus.o_frame_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      vd[i] = '0;
      ve[i] = '0;
    end
  endtask

  task automatic start_frame(input logic [3:0] k);
    bus.i_k_bin = k;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_k_bin = ~k;
    check("busy_after_start", {31'b0, bus.o_busy}, 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e, input bit push);
    check("in_ready_run", {31'b0, bus.o_in_ready}, 32'd1);
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
    if (push) sb.push_back('{data: e, cyc: cyc + 1});
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
  endtask

  task automatic wait_frame(input int fd0);
    for (int i = 0; i < 40 && fd_count == fd0; i++) begin
      @(negedge clk);
      #1;
    end
    check("frame_done_seen", fd_count - fd0, 32'd1);
  endtask

  task automatic run_frame(input logic [3:0] k, input bit toggle, input int start_at);
    int ov0, fd0;
    ov0 = ov_count;
    fd0 = fd_count;
    start_frame(k);
    for (int i = 0; i < N; i++) begin
      if (i == start_at) begin
        bus.i_start = 1'b1;
        bus.i_k_bin = 4'd6;
      end
      send(vd[i], ve[i], 1'b1);
      bus.i_start = 1'b0;
      if (i == N - 1) begin
        check("in_ready_flush", {31'b0, bus.o_in_ready}, 32'd0);
        check("busy_flush", {31'b0, bus.o_busy}, 32'd1);
      end
      if (toggle) @(negedge clk);
    end
    wait_frame(fd0);
    check("out_count", ov_count - ov0, 32'd16);
    check("done_after_last", fd_cyc, last_ov_cyc + 1);
    check("sb_empty", sb.size(), 32'd0);
    @(negedge clk);
    check("done_width", {31'b0, bus.o_frame_done}, 32'd0);
  endtask

  initial begin
    int ov0, fd0;
    nrst = 1'b0;
    bus.i_start = 1'b1;
    bus.i_k_bin = '0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, bus.o_in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, bus.o_out_valid}, 32'd0);
    check("rst_out_data", bus.o_out_data, 32'd0);
    check("rst_frame_done", {31'b0, bus.o_frame_done}, 32'd0);
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    bus.i_start = 1'b0;
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // k=0, unit-ish input through W=1
    clear_vec();
    vd[0] = 32'h4000_0000; ve[0] = RND ? 32'h4000_0000 : 32'h3FFF_0000;
    run_frame(4'd0, 1'b0, -1);

    // k=4: p = 0,4,8,12 -> W = 1, -j, -1, +j
    clear_vec();
    vd[1] = 32'h4000_0000; ve[1] = RND ? 32'h0000_C001 : 32'h0000_C000;
    vd[2] = 32'h4000_0000; ve[2] = 32'hC000_0000;
    vd[3] = 32'h4000_0000; ve[3] = 32'h0000_4000;
    run_frame(4'd4, 1'b0, -1);

    // k=2: saturation at both bounds
    clear_vec();
    vd[0] = 32'h8000_8000; ve[0] = 32'h8001_8001;
    vd[1] = 32'h8000_8000; ve[1] = 32'h8000_0000;
    vd[4] = 32'h8000_8000; ve[4] = 32'h7FFF_7FFF;
    run_frame(4'd2, 1'b0, -1);

    // in_valid toggling 1,0
    clear_vec();
    run_frame(4'd1, 1'b1, -1);

    // reset after 7 accepts; only samples 0..3 clear the pipe before reset
    clear_vec();
    start_frame(4'd2);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: ve[0] = RND ? 32'h4000_0000 : 32'h3FFF_0000;
        1: ve[0] = 32'h2D41_D2BF;
        2: ve[0] = RND ? 32'h0000_C001 : 32'h0000_C000;
        3: ve[0] = 32'hD2BF_D2BF;
        default: ve[0] = '0;
      endcase
      send(32'h4000_0000, ve[0], i < 4);
    end
    fd0 = fd_count;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_mid_in_ready", {31'b0, bus.o_in_ready}, 32'd0);
    nrst = 1'b1;
    ov0 = ov_count;
    repeat (6) @(negedge clk);
    #1;
    check("rst_mid_no_out", ov_count - ov0, 32'd0);
    check("rst_mid_no_done", fd_count - fd0, 32'd0);
    check("rst_mid_sb_empty", sb.size(), 32'd0);
    clear_vec();
    @(negedge clk);
    vd[0] = 32'h4000_0000; ve[0] = RND ? 32'h4000_0000 : 32'h3FFF_0000;
    vd[1] = 32'h4000_0000; ve[1] = RND ? 32'h0000_C001 : 32'h0000_C000;
    run_frame(4'd4, 1'b0, -1);

    // start with k_bin=6 during RUN must be ignored; sequence stays k=4
    clear_vec();
    vd[2] = 32'h4000_0000; ve[2] = 32'hC000_0000;
    vd[3] = 32'h4000_0000; ve[3] = 32'h0000_4000;
    vd[5] = 32'h4000_0000; ve[5] = RND ? 32'h0000_C001 : 32'h0000_C000;
    vd[8] = 32'h4000_0000; ve[8] = RND ? 32'h4000_0000 : 32'h3FFF_0000;
    run_frame(4'd4, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
